// File: rtl/relu_maxpool2d_pkg.sv
// rtl/relu_maxpool2d_pkg.sv - shared sizing helper for the ReLU + 2x2 max-pool block
package relu_maxpool2d_pkg;

   // Index width for a counter or array of n entries, never narrower than one bit.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/relu_maxpool2d_relu_max2.sv
// rtl/relu_maxpool2d_relu_max2.sv - ReLU on the new operand, then unsigned max against a kept operand
module relu_max2 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] keep_a,
   input  logic [DATA_WIDTH-1:0] new_b,
   output logic [DATA_WIDTH-1:0] y
);

   logic [DATA_WIDTH-1:0] b_relu;

   // Non-negative float32 words order the same as unsigned integers.
   always_comb begin
      b_relu = new_b[DATA_WIDTH-1] ? '0 : new_b;
      y      = (b_relu > keep_a) ? b_relu : keep_a;
   end

endmodule

// File: rtl/relu_maxpool2d.sv
// rtl/relu_maxpool2d.sv - streaming ReLU followed by 2x2 stride-2 max-pool over a raster float32 feature map
module relu_maxpool2d
   import relu_maxpool2d_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 56,
   parameter int HEIGHT     = 56
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);

   localparam int CW   = idx_bits(WIDTH);
   localparam int RW   = idx_bits(HEIGHT);
   localparam int HALF = WIDTH / 2;
   localparam int HW   = idx_bits(HALF);

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [DATA_WIDTH-1:0] pair_q, pair_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  frame_done_q, frame_done_d;

   logic [DATA_WIDTH-1:0] line_buf [HALF];
   logic [DATA_WIDTH-1:0] pair_a, pair_max, lb_rd, row_max;
   logic [HW-1:0]         lb_idx;
   logic                  lb_we;

   // On even columns the kept operand is zero, so pair_max is just ReLU(data_in).
   assign pair_a = col_q[0] ? pair_q : '0;
   assign lb_idx = HW'(col_q >> 1);
   assign lb_rd  = line_buf[lb_idx];
   assign lb_we  = valid_in & col_q[0] & ~row_q[0];

   relu_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_pair (
      .keep_a (pair_a),
      .new_b  (data_in),
      .y      (pair_max)
   );

   relu_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_row (
      .keep_a (lb_rd),
      .new_b  (pair_max),
      .y      (row_max)
   );

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      data_out_d   = data_out_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      if (valid_in) begin
         if (col_q == CW'(WIDTH - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         if (!col_q[0]) begin
            pair_d = pair_max;
         end else if (row_q[0]) begin
            valid_out_d  = 1'b1;
            data_out_d   = row_max;
            frame_done_d = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         pair_q       <= '0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Every entry is rewritten in an even row before the odd row reads it, so no reset.
   always_ff @(posedge clk) begin
      if (lb_we) line_buf[lb_idx] <= pair_max;
   end

   assign valid_out  = valid_out_q;
   assign data_out   = data_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2d.sv
// tb/tb_relu_maxpool2d.sv - directed self-checking bench for relu_maxpool2d on a 4x4 frame
module tb_relu_maxpool2d;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic [31:0] data_in = '0;
   logic        valid_out;
   logic [31:0] data_out;
   logic        frame_done;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] last_out = '0;

   logic [31:0] pix     [16];
   logic [31:0] exp_out [4];

   relu_maxpool2d #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " valid_out"}, {31'd0, valid_out}, 32'd0);
      check({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
      check({tag, " data_out hold"}, data_out, last_out);
   endtask

   task automatic bubble();
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      check_idle("bubble");
   endtask

   // Push pixel i of pix[]; out_k >= 0 means this pixel completes window out_k.
   task automatic push(input int i, input int out_k, input bit negate);
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = negate ? (pix[i] | 32'h8000_0000) : pix[i];
      @(posedge clk);
      #1;
      if (out_k >= 0) begin
         last_out = negate ? 32'h0 : exp_out[out_k];
         check($sformatf("px%0d valid_out", i), {31'd0, valid_out}, 32'd1);
         check($sformatf("px%0d data_out", i), data_out, last_out);
         check($sformatf("px%0d frame_done", i), {31'd0, frame_done}, (i == 15) ? 32'd1 : 32'd0);
      end else begin
         check_idle($sformatf("px%0d", i));
      end
   endtask

   task automatic send_frame(input bit negate, input int gaps, input int npix);
      for (int i = 0; i < npix; i++) begin
         push(i, (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1, negate);
         for (int g = 0; g < gaps; g++) bubble();
      end
   endtask

   task automatic load_standard();
      pix = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
              32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
      exp_out = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
   endtask

   initial begin
      load_standard();
      #12;
      check("reset valid_out", {31'd0, valid_out}, 32'd0);
      check("reset data_out", data_out, 32'd0);
      check("reset frame_done", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      send_frame(1'b0, 0, 16);
      send_frame(1'b1, 0, 16);
      bubble();

      send_frame(1'b0, 2, 16);

      // Top-left window all negative, including -0.0; others unchanged.
      pix[0] = 32'hBF800000;
      pix[1] = 32'hC0000000;
      pix[4] = 32'hBF000000;
      pix[5] = 32'h80000000;
      exp_out[0] = 32'h00000000;
      send_frame(1'b0, 0, 16);
      bubble();

      load_standard();
      send_frame(1'b0, 0, 6);
      @(negedge clk);
      valid_in = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async rst valid_out", {31'd0, valid_out}, 32'd0);
      check("async rst data_out", data_out, 32'd0);
      check("async rst frame_done", {31'd0, frame_done}, 32'd0);
      last_out = '0;
      @(negedge clk);
      rst = 1'b0;
      bubble();
      send_frame(1'b0, 0, 16);

      @(negedge clk);
      valid_in = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
